// File: rtl/dff_response_checker.sv
// Checks a D flip-flop with async active-high reset against a one-edge-latency model
// for a programmable number of compare edges, and reports per-session statistics.
module dff_response_checker #(
  parameter int unsigned CNT_W        = 8,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_checks,
  input  logic             dut_rst,
  input  logic             dut_d,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic             busy_q, busy_d;
  logic             exp_q, exp_d;
  logic             cmp_exp_c;
  logic             cmp_fail_c;

  // Next-state, counter and flag logic; the model flop tracks the DUT every cycle.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    chk_d      = chk_q;
    err_d      = err_q;
    first_d    = first_q;
    pass_d     = pass_q;
    mis_d      = 1'b0;
    exp_d      = dut_rst ? 1'b0 : dut_d;
    cmp_exp_c  = dut_rst ? 1'b0 : exp_q;
    cmp_fail_c = (dut_q != cmp_exp_c);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          chk_d   = CNT_ZERO;
          err_d   = CNT_ZERO;
          first_d = CNT_ONES;
          if (num_checks != CNT_ZERO) begin
            state_d = ST_PRIME;
            num_d   = num_checks;
            pass_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end
        end
      end
      ST_PRIME: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        chk_d = chk_q + CNT_ONE;
        if (cmp_fail_c) begin
          mis_d = 1'b1;
          if (err_q != CNT_ONES) begin
            err_d = err_q + CNT_ONE;
          end
          if (first_q == CNT_ONES) begin
            first_d = chk_q;
          end
        end
        // Result is taken here so that pass is valid in the same cycle as done.
        if ((chk_d == num_q) || (STOP_ON_FAIL && cmp_fail_c)) begin
          state_d = ST_DONE;
          pass_d  = (err_d == CNT_ZERO);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_PRIME) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      num_q   <= CNT_ZERO;
      chk_q   <= CNT_ZERO;
      err_q   <= CNT_ZERO;
      first_q <= CNT_ONES;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      exp_q   <= exp_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign mismatch      = mis_q;
  assign chk_cnt       = chk_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench: a behavioural DFF with fault override feeds two checkers (STOP_ON_FAIL 0 and 1);
// a cycle-level session model predicts every output each cycle.
module tb_dff_response_checker;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_checks;
  logic             dut_rst;
  logic             dut_d;
  logic             dut_q;
  logic             ff_q;
  logic             force_en;
  logic             force_val;

  logic             busy_w  [2];
  logic             done_w  [2];
  logic             pass_w  [2];
  logic             mis_w   [2];
  logic [CNT_W-1:0] chk_w   [2];
  logic [CNT_W-1:0] err_w   [2];
  logic [CNT_W-1:0] first_w [2];

  dff_response_checker #(.CNT_W(CNT_W), .STOP_ON_FAIL(1'b0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .num_checks(num_checks),
    .dut_rst(dut_rst), .dut_d(dut_d), .dut_q(dut_q),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .mismatch(mis_w[0]),
    .chk_cnt(chk_w[0]), .err_cnt(err_w[0]), .first_err_idx(first_w[0])
  );

  dff_response_checker #(.CNT_W(CNT_W), .STOP_ON_FAIL(1'b1)) u_dut_sof (
    .clk(clk), .reset(reset), .start(start), .num_checks(num_checks),
    .dut_rst(dut_rst), .dut_d(dut_d), .dut_q(dut_q),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .mismatch(mis_w[1]),
    .chk_cnt(chk_w[1]), .err_cnt(err_w[1]), .first_err_idx(first_w[1])
  );

  // Flip-flop under test, with a bench-controlled override to plant faults on Q.
  always_ff @(posedge clk or posedge dut_rst) begin
    if (dut_rst) ff_q <= 1'b0;
    else         ff_q <= dut_d;
  end
  assign dut_q = force_en ? force_val : ff_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks;
  int n_errors;

  // Per-cycle stimulus, indexed by cycle relative to the start-sampling edge (cycle 0 = PRIME).
  bit rst_v [300];
  bit d_v   [300];
  bit fv_v  [300];
  bit fq_v  [300];

  int               obs_done  [2];
  logic [CNT_W-1:0] fin_chk   [2];
  logic [CNT_W-1:0] fin_err   [2];
  logic [CNT_W-1:0] fin_first [2];
  logic             fin_pass  [2];

  typedef struct {
    int               n;
    int               kind;
    int               poke;
    int               done0;
    logic [CNT_W-1:0] chk0, err0, first0;
    bit               pass0;
    int               done1;
    logic [CNT_W-1:0] chk1, err1, first1;
    bit               pass1;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input int k, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // kind 0: {rst,d} stepping 00,01,10,11 per compare; 1: same with Q forced to 1 on compare 2;
  // 2: D=1 with Q stuck at 0; 3: random with sparse random Q faults.
  task automatic fill_stim(input int kind);
    for (int c = 0; c < 300; c++) begin
      rst_v[c] = 1'b0; d_v[c] = 1'b0; fv_v[c] = 1'b0; fq_v[c] = 1'b0;
      case (kind)
        0, 1: begin
          if (c >= 1) begin
            rst_v[c] = (((c - 1) % 4) >= 2);
            d_v[c]   = (((c - 1) % 2) == 1);
          end
          if (kind == 1 && c == 3) begin fv_v[c] = 1'b1; fq_v[c] = 1'b1; end
        end
        2: begin d_v[c] = 1'b1; fv_v[c] = 1'b1; fq_v[c] = 1'b0; end
        default: begin
          rst_v[c] = ($urandom_range(0, 3) == 0);
          d_v[c]   = 1'($urandom_range(0, 1));
          fv_v[c]  = ($urandom_range(0, 7) == 0);
          fq_v[c]  = 1'($urandom_range(0, 1));
        end
      endcase
    end
  endtask

  // Runs one session from an IDLE checker and compares every output on every cycle.
  task automatic run_session(input int n, input int poke_c);
    int done_cyc [2];
    int nc       [2];
    int err      [2];
    int first    [2];
    bit running  [2];
    bit mis_exp  [2];
    bit prev_rst, prev_d, expv, fail;
    start = 1'b1; num_checks = CNT_W'(n);
    dut_rst = 1'b0; dut_d = 1'b0; force_en = 1'b0; force_val = 1'b0;
    prev_rst = 1'b0; prev_d = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nc[k] = 0; err[k] = 0; first[k] = 255; mis_exp[k] = 1'b0; obs_done[k] = -1;
      running[k]  = (n != 0);
      done_cyc[k] = (n != 0) ? 100000 : 0;
    end
    for (int c = 0; c <= n + 3; c++) begin
      @(posedge clk); #1;
      if (c == poke_c) begin start = 1'b1; num_checks = 8'd7; end
      else begin start = 1'b0; num_checks = CNT_W'(n); end
      dut_rst = rst_v[c]; dut_d = d_v[c]; force_en = fv_v[c]; force_val = fq_v[c];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (done_w[k] === 1'b1 && obs_done[k] < 0) obs_done[k] = c;
        check("busy",          k, c, 32'(busy_w[k]),  32'((n != 0) && (c < done_cyc[k])));
        check("done",          k, c, 32'(done_w[k]),  32'(c == done_cyc[k]));
        check("mismatch",      k, c, 32'(mis_w[k]),   32'(mis_exp[k]));
        check("chk_cnt",       k, c, 32'(chk_w[k]),   32'(nc[k]));
        check("err_cnt",       k, c, 32'(err_w[k]),   32'(err[k]));
        check("first_err_idx", k, c, 32'(first_w[k]), 32'(first[k]));
        check("pass",          k, c, 32'(pass_w[k]),  32'((c >= done_cyc[k]) && (err[k] == 0)));
      end
      // A correct DFF shows last cycle's D one edge later, or 0 while its reset is high.
      expv = dut_rst ? 1'b0 : (prev_rst ? 1'b0 : prev_d);
      fail = (dut_q != expv);
      for (int k = 0; k < 2; k++) begin
        mis_exp[k] = 1'b0;
        if (running[k] && c >= 1) begin
          nc[k]++;
          if (fail) begin
            mis_exp[k] = 1'b1;
            if (err[k] < 255) err[k]++;
            if (first[k] == 255) first[k] = nc[k] - 1;
          end
          if (nc[k] == n || (k == 1 && fail)) begin
            running[k]  = 1'b0;
            done_cyc[k] = c + 1;
          end
        end
      end
      prev_rst = dut_rst; prev_d = dut_d;
    end
    for (int k = 0; k < 2; k++) begin
      fin_chk[k] = chk_w[k]; fin_err[k] = err_w[k];
      fin_first[k] = first_w[k]; fin_pass[k] = pass_w[k];
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_busy"},  k, -1, 32'(busy_w[k]),  32'd0);
      check({tag, "_done"},  k, -1, 32'(done_w[k]),  32'd0);
      check({tag, "_pass"},  k, -1, 32'(pass_w[k]),  32'd0);
      check({tag, "_mis"},   k, -1, 32'(mis_w[k]),   32'd0);
      check({tag, "_chk"},   k, -1, 32'(chk_w[k]),   32'd0);
      check({tag, "_err"},   k, -1, 32'(err_w[k]),   32'd0);
      check({tag, "_first"}, k, -1, 32'(first_w[k]), 32'hFF);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    //          n    kind poke done0 chk0   err0   first0 p0  done1 chk1   err1   first1 p1
    vecs[0] = '{4,   0,   -1,  5,    8'd4,  8'd0,  8'hFF, 1,  5,    8'd4,  8'd0,  8'hFF, 1};
    vecs[1] = '{4,   1,   -1,  5,    8'd4,  8'd1,  8'd2,  0,  4,    8'd3,  8'd1,  8'd2,  0};
    vecs[2] = '{255, 2,   1,   256,  8'hFF, 8'hFF, 8'd0,  0,  2,    8'd1,  8'd1,  8'd0,  0};
    vecs[3] = '{0,   0,   -1,  0,    8'd0,  8'd0,  8'hFF, 1,  0,    8'd0,  8'd0,  8'hFF, 1};

    reset = 1'b0; start = 1'b0; num_checks = '0;
    dut_rst = 1'b0; dut_d = 1'b0; force_en = 1'b0; force_val = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);

    // Directed sessions from the table.
    for (int i = 0; i < 4; i++) begin
      fill_stim(vecs[i].kind);
      run_session(vecs[i].n, vecs[i].poke);
      check("vec_done_cycle", 0, i, 32'(obs_done[0]),  32'(vecs[i].done0));
      check("vec_chk",        0, i, 32'(fin_chk[0]),   32'(vecs[i].chk0));
      check("vec_err",        0, i, 32'(fin_err[0]),   32'(vecs[i].err0));
      check("vec_first",      0, i, 32'(fin_first[0]), 32'(vecs[i].first0));
      check("vec_pass",       0, i, 32'(fin_pass[0]),  32'(vecs[i].pass0));
      check("vec_done_cycle", 1, i, 32'(obs_done[1]),  32'(vecs[i].done1));
      check("vec_chk",        1, i, 32'(fin_chk[1]),   32'(vecs[i].chk1));
      check("vec_err",        1, i, 32'(fin_err[1]),   32'(vecs[i].err1));
      check("vec_first",      1, i, 32'(fin_first[1]), 32'(vecs[i].first1));
      check("vec_pass",       1, i, 32'(fin_pass[1]),  32'(vecs[i].pass1));
    end

    // Reset pulsed during CHECK after two compares aborts the session without done.
    fill_stim(0);
    start = 1'b1; num_checks = 8'd4;
    for (int c = 0; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      dut_rst = rst_v[c]; dut_d = d_v[c]; force_en = fv_v[c]; force_val = fq_v[c];
    end
    #1;
    check("abort_pre_chk",  0, 3, 32'(chk_w[0]),  32'd2);
    check("abort_pre_busy", 1, 3, 32'(busy_w[1]), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    check_reset_vals("abort_hold");
    #1 reset = 1'b1;
    run_session(1, -1);
    check("post_abort_done", 0, 0, 32'(obs_done[0]), 32'd2);
    check("post_abort_pass", 0, 0, 32'(fin_pass[0]), 32'd1);
    check("post_abort_pass", 1, 0, 32'(fin_pass[1]), 32'd1);

    // Randomized sessions checked against the model.
    for (int r = 0; r < 20; r++) begin
      fill_stim(3);
      run_session(int'($urandom_range(1, 40)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dff_response_checker.md
DFF_RESPONSE_CHECKER -- requirements
Module: dff_response_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of all counters and count ports.
REQ-002 The block SHALL have parameter STOP_ON_FAIL, default 0; when set to 1, a session ends at its first mismatch.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset of all checker state.
REQ-005 Port start, input, 1 bit: request to begin a checking session; sampled only in IDLE.
REQ-006 Port num_checks, input, CNT_W bits: number of compare edges in the session; sampled with start.
REQ-007 Port dut_rst, input, 1 bit: the active-high asynchronous reset currently driven to the flip-flop under test.
REQ-008 Port dut_d, input, 1 bit: the D value currently driven to the flip-flop under test.
REQ-009 Port dut_q, input, 1 bit: the Q value observed from the flip-flop under test.
REQ-010 Port busy, output, 1 bit: high in PRIME and CHECK.
REQ-011 Port done, output, 1 bit: one-cycle pulse marking the end of a session.
REQ-012 Port pass, output, 1 bit: session result; valid from done and held until the next accepted start.
REQ-013 Port mismatch, output, 1 bit: one-cycle pulse on each failed compare.
REQ-014 Port chk_cnt, output, CNT_W bits: number of compares performed in the current or last session.
REQ-015 Port err_cnt, output, CNT_W bits: number of mismatches; saturates at all-ones.
REQ-016 Port first_err_idx, output, CNT_W bits: value of chk_cnt at the first mismatch; all-ones when there has been no mismatch.

Function
REQ-017 FSM states SHALL be IDLE, PRIME, CHECK and DONE, with IDLE as the reset state.
REQ-018 IDLE transitions:
- start=1 and num_checks!=0: go to PRIME, latch num_checks, clear chk_cnt and err_cnt, set first_err_idx to all-ones, clear pass.
- start=1 and num_checks==0: go directly to DONE with pass=1.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 The internal model register exp_q SHALL load (dut_rst ? 0 : dut_d) on every rising edge, in every state.
REQ-021 PRIME SHALL last exactly one cycle, with no compare, and then go to CHECK.
REQ-022 On each CHECK edge the block SHALL:
- compare dut_q against expected = (dut_rst ? 0 : exp_q), giving a latency of one edge from D to the checked Q;
- increment chk_cnt.
REQ-023 On a mismatch the block SHALL:
- pulse mismatch in the following cycle;
- increment err_cnt, saturating at all-ones;
- load first_err_idx with the pre-increment chk_cnt, only if first_err_idx is still all-ones.
REQ-024 CHECK SHALL go to DONE on the edge where the incremented chk_cnt equals the latched num_checks.
REQ-025 If STOP_ON_FAIL=1, CHECK SHALL also go to DONE on the first mismatch.
REQ-026 DONE SHALL last one cycle, assert done, and set pass = (err_cnt==0) including any mismatch from the final compare, then return to IDLE.
REQ-027 chk_cnt, err_cnt, first_err_idx and pass SHALL hold their values in IDLE.
REQ-028 When num_checks is all-ones, the session SHALL run the full all-ones count, and chk_cnt SHALL NOT wrap before DONE.

Reset
REQ-029 When reset=0 (asynchronous), all outputs SHALL go low immediately, except first_err_idx, which SHALL go to all-ones; FSM=IDLE and exp_q=0.
REQ-030 A reset in the middle of a session SHALL abort it, with no done pulse; on release the block SHALL be in IDLE and accept start on the first edge after release.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Correct DFF driven with {dut_rst,dut_d} stepping 00,01,10,11 (each held 1 cycle), num_checks=4 -> done after 6 cycles from start, pass=1, chk_cnt=4, err_cnt=0, first_err_idx=8'hFF.
- dut_q forced to 1 while dut_rst=1 on compare 2, num_checks=4, STOP_ON_FAIL=0 -> one mismatch pulse, err_cnt=1, first_err_idx=2, chk_cnt=4, pass=0.
- Same fault with STOP_ON_FAIL=1 -> done on compare 2, chk_cnt=3, pass=0.
- start with num_checks=0 -> done on the next cycle, pass=1, busy never high.
- reset pulsed low during CHECK at chk_cnt=2 -> all outputs reset at once, no done; a new start with num_checks=1 completes with pass=1.
- dut_q stuck at 0 with dut_d=1, num_checks=255 (CNT_W=8) -> err_cnt=255 (saturated), first_err_idx=0, chk_cnt=255, pass=0; start asserted while busy is ignored.
